// File: rtl/ucsbece154b_mem_arb_pkg.sv
// Shared types and helpers for the two-port SDRAM read arbiter.
package ucsbece154b_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BURST = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    localparam int DEFAULT_BLOCK_WORDS = 4;

    // Bits needed to index value items; never narrower than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) width++;
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/ucsbece154b_beat_counter.sv
// Wrapping beat counter: counts enabled cycles 0..MAX_COUNT-1, tc flags the last value.
module ucsbece154b_beat_counter #(
    parameter int MAX_COUNT = 4,
    parameter int WIDTH     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tc
);

    logic [WIDTH-1:0] count;

    assign tc = (count == WIDTH'(MAX_COUNT - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/ucsbece154b_mem_arbiter.sv
// Grants the single SDRAM burst-read port to the icache or dcache and steers beats back.
// Build option: define MEM_ARB_RR_EN for round-robin ties; otherwise the icache always wins ties.
module ucsbece154b_mem_arbiter
    import ucsbece154b_mem_arb_pkg::*;
#(
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IReadRequest,
    input  logic [31:0] IReadAddress,
    output logic [31:0] IDataIn,
    output logic        IDataReady,
    input  logic        DReadRequest,
    input  logic [31:0] DReadAddress,
    output logic [31:0] DDataIn,
    output logic        DDataReady,
    output logic        MemReadRequest,
    output logic [31:0] MemReadAddress,
    input  logic [31:0] MemDataIn,
    input  logic        MemDataReady,
    output logic        IGrant,
    output logic        DGrant
);

    localparam int COUNT_WIDTH = clog2(BLOCK_WORDS);

    arb_state_t state;
    logic       beat;
    logic       last_beat;
    logic       any_request;
    logic       pick_i;

    assign any_request = IReadRequest | DReadRequest;
    assign beat        = MemDataReady & (state == BURST);

`ifdef MEM_ARB_RR_EN
    logic last_d;

    // On a tie the port that was not served most recently wins.
    assign pick_i = IReadRequest & (~DReadRequest | last_d);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_d <= 1'b1;
        end else if (state == IDLE && any_request) begin
            last_d <= ~pick_i;
        end
    end
`else
    assign pick_i = IReadRequest;
`endif

    ucsbece154b_beat_counter #(
        .MAX_COUNT (BLOCK_WORDS),
        .WIDTH     (COUNT_WIDTH)
    ) u_beat_counter (
        .clk   (clk),
        .reset (reset),
        .en    (beat),
        .clr   (state == START),
        .tc    (last_beat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            MemReadRequest <= 1'b0;
            MemReadAddress <= '0;
            IGrant         <= 1'b0;
            DGrant         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_request) begin
                        state          <= START;
                        MemReadRequest <= 1'b1;
                        MemReadAddress <= pick_i ? IReadAddress : DReadAddress;
                        IGrant         <= pick_i;
                        DGrant         <= ~pick_i;
                    end
                end
                START: begin
                    MemReadRequest <= 1'b0;
                    state          <= BURST;
                end
                BURST: begin
                    if (beat && last_beat) begin
                        state  <= DRAIN;
                        IGrant <= 1'b0;
                        DGrant <= 1'b0;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Beats are forwarded combinationally; the idle port's data bus is held at zero.
    assign IDataReady = beat & IGrant;
    assign DDataReady = beat & DGrant;
    assign IDataIn    = IGrant ? MemDataIn : '0;
    assign DDataIn    = DGrant ? MemDataIn : '0;

endmodule
